// File: rtl/rx_port_mc.sv
// rx_port_mc: switch receive port.
//   Buffers ingress packets (payload + destination mask) in a circular FIFO and
//   presents the head packet to the crossbar. A multicast head stays at the head
//   until every target has granted it. Grants that arrive before the packet
//   finishes are remembered in a pending mask. Optional features: drop-on-full
//   ingress, zero-target filtering, a head-of-line timeout flush, an occupancy
//   output and saturating drop/timeout counters.
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   valid_in/data_in/target_in  ingress packet
//   ready_out                   ingress ready (!full, or always 1 in drop mode)
//   grant_vec                   per-TX-port grant for the head packet
//   pkt_valid/pkt_data          head packet toward the crossbar
//   pkt_target                  targets the head packet is still waiting for
//   level                       FIFO occupancy, 0..DEPTH
//   drop_cnt, timeout_cnt       saturating statistics counters
module rx_port_mc #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 16,
  parameter int DROP_ON_FULL = 0,
  parameter int TIMEOUT      = 0,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [NUM_PORTS-1:0]     target_in,
  output logic                     ready_out,
  input  logic [NUM_PORTS-1:0]     grant_vec,
  output logic                     pkt_valid,
  output logic [DATA_W-1:0]        pkt_data,
  output logic [NUM_PORTS-1:0]     pkt_target,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         timeout_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int AGE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [0:0] ST_FRESH   = 1'b0;
  localparam logic [0:0] ST_PARTIAL = 1'b1;

  logic [DATA_W-1:0]    data_mem [DEPTH];
  logic [NUM_PORTS-1:0] tgt_mem  [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [0:0]           state_q, state_d;
  logic [NUM_PORTS-1:0] pending_q, pending_d;
  logic [AGE_W-1:0]     age_q, age_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]     timeout_cnt_q, timeout_cnt_d;

  logic                 empty, full, push, pop, drop, done, expire;
  logic [NUM_PORTS-1:0] owed;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    empty      = (level_q == '0);
    // Full is taken from the registered level: a pop in the same cycle does
    // not make room for the push.
    full       = (level_q == LVL_W'(DEPTH));
    ready_out  = (DROP_ON_FULL != 0) ? 1'b1 : !full;

    pkt_data   = data_mem[rd_ptr_q];
    pkt_valid  = !empty;
    pkt_target = empty ? '0 : tgt_mem[rd_ptr_q];
    if (state_q == ST_PARTIAL) begin
      pkt_valid  = 1'b1;
      pkt_target = pending_q;
    end

    // Grants outside pkt_target fall away in the mask; with no valid head
    // pkt_target is zero, so grant_vec has no effect.
    owed   = pkt_target & ~grant_vec;
    done   = pkt_valid && (owed == '0);
    expire = (TIMEOUT > 0) && pkt_valid && !done &&
             (age_q == AGE_W'(TIMEOUT - 1));
    pop    = done || expire;
    push   = valid_in && !full && (target_in != '0);
    drop   = valid_in && ((target_in == '0) || (full && (DROP_ON_FULL != 0)));

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;

    state_d   = state_q;
    pending_d = pending_q;
    age_d     = age_q;
    if (pop) begin
      state_d   = ST_FRESH;
      pending_d = '0;
      age_d     = '0;
    end else if (pkt_valid) begin
      // Head is still waiting: remember which targets have not granted yet.
      state_d   = ST_PARTIAL;
      pending_d = owed;
      if (TIMEOUT > 0) age_d = age_q + 1'b1;
    end

    drop_cnt_d    = drop_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    if (drop && (drop_cnt_q != '1))      drop_cnt_d    = drop_cnt_q + 1'b1;
    if (expire && (timeout_cnt_q != '1)) timeout_cnt_d = timeout_cnt_q + 1'b1;
  end

  // NOTE: the payload storage has no reset; the pointers and level mark which
  // entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= data_in;
      tgt_mem[wr_ptr_q]  <= target_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from the values computed in the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      state_q       <= ST_FRESH;
      pending_q     <= '0;
      age_q         <= '0;
      drop_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      state_q       <= state_d;
      pending_q     <= pending_d;
      age_q         <= age_d;
      drop_cnt_q    <= drop_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign level       = level_q;
  assign drop_cnt    = drop_cnt_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule
